// File: rtl/full_subtractor_structural.sv
// Ripple-borrow full subtractor built from gate-level 1-bit cells: {bout, sub} = a - b - bin.
// Define FSUB_COMB_OUT_EN to drop the output register and present the result combinationally.

module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic axb;
    logic not_a;
    logic not_axb;
    logic borrow_gen;
    logic borrow_prop;

    xor g_axb   (axb, a, b);
    xor g_d     (d, axb, bin);
    not g_na    (not_a, a);
    not g_naxb  (not_axb, axb);
    // Borrow is generated when a=0,b=1, and propagated from below when a==b.
    and g_gen   (borrow_gen, not_a, b);
    and g_prop  (borrow_prop, not_axb, bin);
    or  g_bout  (bout, borrow_gen, borrow_prop);
endmodule

module full_subtractor_structural #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_vld,
    output logic             bout,
    output logic [WIDTH-1:0] sub,
    output logic             out_vld
);
    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff;

    assign br[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (br[i]),
            .d    (diff[i]),
            .bout (br[i+1])
        );
    end

`ifdef FSUB_COMB_OUT_EN
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign sub     = diff;
    assign bout    = br[WIDTH];
    assign out_vld = in_vld;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            sub     <= '0;
            bout    <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld;
            // NOTE: no else branch here is intentional; inside always_ff it means "hold", never a latch.
            if (in_vld) begin
                sub  <= diff;
                bout <= br[WIDTH];
            end
        end
    end
`endif
endmodule

// File: tb/tb_full_subtractor_structural.sv
// Scoreboard bench for full_subtractor_structural: a 1-bit and an 8-bit instance driven
// side by side, expected results queued at issue time and popped by a monitor on out_vld.

module tb_full_subtractor_structural;
    typedef struct packed {
        logic       bout;
        logic [7:0] sub;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_vld;
    logic       a1, b1, bin1, bout1, sub1, ov1;
    logic [7:0] a8, b8, sub8;
    logic       bin8, bout8, ov8;

    exp_t q1[$];
    exp_t q8[$];
    exp_t last1, last8;
    int   checks   = 0;
    int   failures = 0;

    // A B BIN -> {BOUT, SUB}, indexed by {a, b, bin}.
    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    full_subtractor_structural #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .bin(bin1), .a(a1), .b(b1), .in_vld(in_vld),
        .bout(bout1), .sub(sub1), .out_vld(ov1)
    );

    full_subtractor_structural #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .bin(bin8), .a(a8), .b(b8), .in_vld(in_vld),
        .bout(bout8), .sub(sub8), .out_vld(ov8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic; a negative difference means a borrow out of the MSB.
    function automatic exp_t model(input int w, input int a, input int b, input int bin);
        exp_t e;
        int   d;
        d      = a - b - bin;
        e.bout = (d < 0);
        e.sub  = 8'((d + (1 << w)) % (1 << w));
        return e;
    endfunction

    task automatic push1(input exp_t e);
        q1.push_back(e);
        last1 = e;
    endtask

    task automatic push8(input exp_t e);
        q8.push_back(e);
        last8 = e;
    endtask

    task automatic drive(input logic v, input logic ia1, input logic ib1, input logic ibin1,
                         input logic [7:0] ia8, input logic [7:0] ib8, input logic ibin8);
        in_vld = v;
        a1 = ia1; b1 = ib1; bin1 = ibin1;
        a8 = ia8; b8 = ib8; bin8 = ibin8;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ov1) begin
            if (q1.size() == 0) begin
                check("w1_unexpected_out_vld", 32'(ov1), 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("w1_sub", 32'(sub1), 32'(e.sub[0]));
                check("w1_bout", 32'(bout1), 32'(e.bout));
            end
        end
        if (ov8) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_out_vld", 32'(ov8), 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_sub", 32'(sub8), 32'(e.sub));
                check("w8_bout", 32'(bout8), 32'(e.bout));
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("reset_w1_out_vld", 32'(ov1), 32'd0);
        check("reset_w1_sub", 32'(sub1), 32'd0);
        check("reset_w1_bout", 32'(bout1), 32'd0);
        check("reset_w8_out_vld", 32'(ov8), 32'd0);
        check("reset_w8_sub", 32'(sub8), 32'd0);
        check("reset_w8_bout", 32'(bout8), 32'd0);
        rst = 1'b0;

`ifdef FSUB_COMB_OUT_EN
        in_vld = 1'b1;
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        #1;
        check("comb_same_cycle_out_vld", 32'(ov1), 32'd1);
        check("comb_same_cycle_sub", 32'(sub1), 32'd1);
        check("comb_same_cycle_bout", 32'(bout1), 32'd0);
        in_vld = 1'b0;
        @(posedge clk);
        #1;
`endif

        // Full 1-bit truth table from the constant table; 8-bit side gets random operands.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            logic [7:0] ra, rb;
            logic       rbin;
            exp_t       e;
            idx  = 3'(i);
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            e.bout = tt[i][1];
            e.sub  = {7'd0, tt[i][0]};
            push1(e);
            push8(model(8, int'(ra), int'(rb), int'(rbin)));
            drive(1'b1, idx[2], idx[1], idx[0], ra, rb, rbin);
        end

        // Double-borrow and the two 8-bit boundary cases with hand-derived results.
        push1('{bout: 1'b1, sub: 8'h00});
        push8('{bout: 1'b1, sub: 8'hFF});
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0);
        push1('{bout: 1'b0, sub: 8'h01});
        push8('{bout: 1'b0, sub: 8'h2F});
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h50, 8'h20, 1'b1);

`ifndef FSUB_COMB_OUT_EN
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h55, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'hF0, 1'b1);
        check("hold_w1_out_vld", 32'(ov1), 32'd0);
        check("hold_w1_sub", 32'(sub1), 32'(last1.sub[0]));
        check("hold_w1_bout", 32'(bout1), 32'(last1.bout));
        check("hold_w8_out_vld", 32'(ov8), 32'd0);
        check("hold_w8_sub", 32'(sub8), 32'(last8.sub));
        check("hold_w8_bout", 32'(bout8), 32'(last8.bout));

        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h01, 1'b0);
        rst = 1'b0;
        check("rst_wins_w1_out_vld", 32'(ov1), 32'd0);
        check("rst_wins_w1_sub", 32'(sub1), 32'd0);
        check("rst_wins_w8_out_vld", 32'(ov8), 32'd0);
        check("rst_wins_w8_sub", 32'(sub8), 32'd0);
        check("rst_wins_w8_bout", 32'(bout8), 32'd0);
`endif

        for (int n = 0; n < 300; n++) begin
            logic       v;
            logic [2:0] r1;
            logic [7:0] ra, rb;
            logic       rbin;
            v    = ($urandom_range(3) != 0);
            r1   = 3'($urandom);
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            if (n % 16 == 0) begin
                ra = 8'h00;
                rb = 8'hFF;
                rbin = 1'b1;
            end
            if (v) begin
                push1(model(1, int'(r1[2]), int'(r1[1]), int'(r1[0])));
                push8(model(8, int'(ra), int'(rb), int'(rbin)));
            end
            drive(v, r1[2], r1[1], r1[0], ra, rb, rbin);
        end

        for (int n = 0; n < 10 && (q1.size() != 0 || q8.size() != 0); n++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
        @(posedge clk);
        check("drain_w1_pending", 32'(q1.size()), 32'd0);
        check("drain_w8_pending", 32'(q8.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
